// File: rtl/seg7_mux_scan.sv
// seg7_mux_scan: time-multiplexed hex driver for a common-anode 7-segment
// display. Scans NUM_DIGITS digits with an anti-ghosting blank window at the
// start of each slot. Display data is double-buffered: load fills a pending
// buffer which is promoted to the active buffer only at the frame wrap.
module seg7_mux_scan #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 125000,
  parameter int BLANK_CYCLES     = 64,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      lz_en,
  input  logic                      load,
  output logic [NUM_DIGITS-1:0]     digit,
  output logic [6:0]                ssegt,
  output logic                      dp,
  output logic                      frame_done,
  output logic                      busy_pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7_low(input logic [3:0] n);
    case (n)
      4'h0: hex7_low = 7'b1000000;
      4'h1: hex7_low = 7'b1111001;
      4'h2: hex7_low = 7'b0100100;
      4'h3: hex7_low = 7'b0110000;
      4'h4: hex7_low = 7'b0011001;
      4'h5: hex7_low = 7'b0010010;
      4'h6: hex7_low = 7'b0000010;
      4'h7: hex7_low = 7'b1111000;
      4'h8: hex7_low = 7'b0000000;
      4'h9: hex7_low = 7'b0010000;
      4'hA: hex7_low = 7'b0001000;
      4'hB: hex7_low = 7'b0000011;
      4'hC: hex7_low = 7'b1000110;
      4'hD: hex7_low = 7'b0100001;
      4'hE: hex7_low = 7'b0000110;
      default: hex7_low = 7'b0001110;
    endcase
  endfunction

  logic [PW-1:0]             presc_reg, presc_next;
  logic [IW-1:0]             idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0]   pend_val_reg, act_val_reg;
  logic [NUM_DIGITS-1:0]     pend_dp_reg, act_dp_reg;
  logic [NUM_DIGITS-1:0]     pend_blank_reg, act_blank_reg;
  logic                      busy_reg;
  logic                      frame_done_reg;
  logic [NUM_DIGITS-1:0]     digit_reg, digit_next;
  logic [6:0]                sseg_reg, sseg_next;
  logic                      dp_reg, dp_next;

  logic                      slot_end, wrap, in_blank, dark;
  logic [3:0]                nibble;
  logic [NUM_DIGITS-1:0]     upper_zero, lz_supp, onehot;

  assign slot_end = (presc_reg == PRESC_LAST);
  assign wrap     = slot_end && (idx_reg == IDX_LAST);
  assign nibble   = act_val_reg[{idx_reg, 2'b00} +: 4];
  assign onehot   = NUM_DIGITS'(1) << idx_reg;

  // upper_zero[i]: digit i and every digit above it hold nibble 0.
  // Digit 0 is never suppressed so a zero value still shows "0".
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = (act_val_reg[4*NUM_DIGITS-1:4*gi] == '0);
      if (gi == 0) begin : g_d0
        assign lz_supp[gi] = 1'b0;
      end else begin : g_dn
        assign lz_supp[gi] = lz_en & upper_zero[gi];
      end
    end
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (presc_reg < PW'(BLANK_CYCLES));
    end
  endgenerate

  assign dark = act_blank_reg[idx_reg] | lz_supp[idx_reg];

  // Scan counters: prescaler per slot, digit index wraps once per frame.
  always_comb begin
    presc_next = presc_reg + PW'(1);
    idx_next   = idx_reg;
    if (slot_end) begin
      presc_next = '0;
      idx_next   = wrap ? '0 : idx_reg + IW'(1);
    end
  end

  // Output pattern for the current slot, registered below for 1-cycle latency.
  always_comb begin
    digit_next = DIG_OFF;
    sseg_next  = SEG_OFF;
    dp_next    = DP_OFF;
    if (!in_blank) begin
      digit_next = (DIGIT_ACTIVE_LOW != 0) ? ~onehot : onehot;
      if (!dark) begin
        sseg_next = (SEG_ACTIVE_LOW != 0) ? hex7_low(nibble) : ~hex7_low(nibble);
        dp_next   = (SEG_ACTIVE_LOW != 0) ? ~act_dp_reg[idx_reg] : act_dp_reg[idx_reg];
      end
    end
  end

  // Scan state and frame-wrap pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      idx_reg        <= idx_next;
      frame_done_reg <= wrap;
    end
  end

  // Double buffer: load fills pending; the wrap promotes the old pending
  // contents, so a load on the wrap cycle stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_blank_reg <= '0;
      act_val_reg    <= '0;
      act_dp_reg     <= '0;
      act_blank_reg  <= '0;
      busy_reg       <= 1'b0;
    end else begin
      if (wrap && busy_reg) begin
        act_val_reg   <= pend_val_reg;
        act_dp_reg    <= pend_dp_reg;
        act_blank_reg <= pend_blank_reg;
      end
      if (load) begin
        pend_val_reg   <= value;
        pend_dp_reg    <= dp_in;
        pend_blank_reg <= blank_in;
        busy_reg       <= 1'b1;
      end else if (wrap) begin
        busy_reg       <= 1'b0;
      end
    end
  end

  // Registered display pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_reg <= DIG_OFF;
      sseg_reg  <= SEG_OFF;
      dp_reg    <= DP_OFF;
    end else begin
      digit_reg <= digit_next;
      sseg_reg  <= sseg_next;
      dp_reg    <= dp_next;
    end
  end

  assign digit        = digit_reg;
  assign ssegt        = sseg_reg;
  assign dp           = dp_reg;
  assign frame_done   = frame_done_reg;
  assign busy_pending = busy_reg;

endmodule

// File: tb/tb_seg7_mux_scan.sv
// Table-driven bench for seg7_mux_scan: 4 digits, 4-cycle slots, 1 blank cycle.
module tb_seg7_mux_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic        lz_en, load;
  logic [3:0]  digit;
  logic [6:0]  ssegt;
  logic        dp, frame_done, busy_pending;

  seg7_mux_scan #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .load(load), .digit(digit),
    .ssegt(ssegt), .dp(dp), .frame_done(frame_done),
    .busy_pending(busy_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpi;
    logic [3:0]  bli;
    logic        lz;
    logic [27:0] seg;   // expected {d3,d2,d1,d0} active-low patterns
    logic [3:0]  dpo;   // expected dp pin per slot
  } vec_t;

  vec_t tbl [8];
  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_busy;
  logic pend_load;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic drive(input int k);
    value     = tbl[k].value;
    dp_in     = tbl[k].dpi;
    blank_in  = tbl[k].bli;
    load      = 1'b1;
    pend_load = 1'b1;
  endtask

  // Checks one frame of record k, starting just after a frame_done sample.
  task automatic check_frame(input int k, input int l1_at, input int l1_k,
                             input int l2_at, input int l2_k);
    logic [3:0] one;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    int         slot, ph;
    one   = 4'b0001;
    lz_en = tbl[k].lz;
    for (int j = 0; j < 16; j++) begin
      step();
      if (j == 15)       exp_busy = pend_load;
      else if (pend_load) exp_busy = 1'b1;
      pend_load = 1'b0;
      load      = 1'b0;
      slot = j / 4;
      ph   = j % 4;
      e_dig = (ph == 0) ? 4'hF : ~(one << slot);
      e_seg = (ph == 0) ? 7'h7F : tbl[k].seg[slot*7 +: 7];
      e_dp  = (ph == 0) ? 1'b1 : tbl[k].dpo[slot];
      check($sformatf("frame%0d_step%0d", k, j),
            {digit, ssegt, dp, frame_done, busy_pending},
            {e_dig, e_seg, e_dp, (j == 15), exp_busy});
      $display("vec rec=%0d step=%0d digit=%b ssegt=%b dp=%b fd=%b busy=%b",
               k, j, digit, ssegt, dp, frame_done, busy_pending);
      if (j == l1_at) drive(l1_k);
      if (j == l2_at) drive(l2_k);
    end
  endtask

  initial begin
    bit found;
    int cnt;
    tbl[0] = '{16'h12AF, 4'b0000, 4'b0000, 1'b0,
               {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    tbl[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b1111};
    tbl[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    tbl[3] = '{16'h3456, 4'b0100, 4'b0001, 1'b0,
               {7'b0110000, 7'b0011001, 7'b0010010, 7'b1111111}, 4'b1011};
    tbl[4] = '{16'hB987, 4'b1111, 4'b0000, 1'b1,
               {7'b0000011, 7'b0010000, 7'b0000000, 7'b1111000}, 4'b0000};
    tbl[5] = '{16'h0EDC, 4'b1000, 4'b0000, 1'b1,
               {7'b1111111, 7'b0000110, 7'b0100001, 7'b1000110}, 4'b1111};
    tbl[6] = '{16'h0006, 4'b0000, 4'b0000, 1'b0,
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b0000010}, 4'b1111};
    tbl[7] = '{16'h0100, 4'b0001, 4'b0000, 1'b1,
               {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}, 4'b1110};

    rst_n = 1'b0; value = '0; dp_in = '0; blank_in = '0;
    lz_en = 1'b0; load = 1'b0; pend_load = 1'b0; exp_busy = 1'b0;
    repeat (3) step();
    check("reset", {digit, ssegt, dp, frame_done, busy_pending},
          {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    $display("vec reset digit=%b ssegt=%b dp=%b", digit, ssegt, dp);

    // First load straight out of reset, then wait for the first wrap.
    drive(0);
    rst_n = 1'b1;
    step();
    load = 1'b0; pend_load = 1'b0;
    check("busy_after_load", {13'b0, busy_pending}, 14'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (frame_done) found = 1'b1;
    end
    check("first_wrap_seen", {13'b0, found}, 14'd1);
    exp_busy = 1'b0;
    check("busy_clear_at_wrap", {13'b0, busy_pending}, 14'd0);

    // Each frame shows its record while the next record loads mid-frame.
    check_frame(0, 3, 1, -1, 0);
    check_frame(1, 3, 2, -1, 0);
    check_frame(2, 3, 3, -1, 0);
    check_frame(3, 3, 4, -1, 0);
    check_frame(4, 2, 6, 9, 5);    // two loads in one frame: last wins
    check_frame(5, 3, 6, 14, 7);   // second load lands on the wrap edge
    check_frame(6, -1, 0, -1, 0);
    check_frame(7, -1, 0, -1, 0);

    // Reset mid-slot with pending data: everything returns to idle.
    lz_en = 1'b0;
    repeat (5) step();
    drive(4);
    step();
    load = 1'b0; pend_load = 1'b0;
    rst_n = 1'b0;
    step();
    check("midslot_reset", {digit, ssegt, dp, frame_done, busy_pending},
          {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    step();
    check("restart_blank", {digit, ssegt, dp, frame_done, busy_pending},
          {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    step();
    check("restart_digit0", {digit, ssegt, dp, frame_done, busy_pending},
          {4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0});
    $display("vec restart digit=%b ssegt=%b dp=%b", digit, ssegt, dp);
    cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      cnt++;
      if (frame_done) found = 1'b1;
    end
    check("restart_wrap_delay", 14'(cnt), 14'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_mux_scan.md
Name: seg7_mux_scan

Overview:
Time-multiplexed driver for a common-anode multi-digit 7-segment display. It scans NUM_DIGITS hex digits, with per-digit decimal point and blanking, optional leading-zero suppression, and an anti-ghosting blank window at each digit switch. New values are double-buffered and take effect only at a frame boundary, so the display never tears. It sits between the counter/datapath logic and the board display pins and replaces single-digit static decoding.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 125000, clock cycles each digit is held (>= BLANK_CYCLES+2)
BLANK_CYCLES, 64, cycles at the start of each digit slot with all digits off (0 disables)
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs active low
DIGIT_ACTIVE_LOW, 1, 1 = digit enables active low

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is LS
dp_in  in  NUM_DIGITS  decimal point request per digit (1 = on)
blank_in  in  NUM_DIGITS  force digit i dark (1 = blank)
lz_en  in  1  leading-zero suppression enable
load  in  1  capture value/dp_in/blank_in into pending buffer
digit  out  NUM_DIGITS  digit enables, one-hot per polarity
ssegt  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point segment
frame_done  out  1  one-cycle pulse when the scan wraps to digit 0
busy_pending  out  1  pending buffer holds data not yet displayed

Behaviour:
- Reset (rst_n=0 at a clk edge): prescaler=0, idx=0, active and pending buffers=0, busy_pending=0, frame_done=0; digit=all inactive (all 1s when DIGIT_ACTIVE_LOW), ssegt=all off (7'b1111111 when SEG_ACTIVE_LOW), dp=off. Reset asserted mid-frame aborts the scan immediately. Pending data is discarded.
- Prescaler counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 on the next cycle, and idx advances. idx wraps from NUM_DIGITS-1 to 0.
- Wrap cycle (idx NUM_DIGITS-1 -> 0): frame_done=1 for exactly one cycle, the cycle in which idx becomes 0. If busy_pending=1, the pending buffer is copied to the active buffer on that same edge and busy_pending clears.
- load=1: the pending buffer captures its inputs and busy_pending sets on the next edge. A second load before the frame wrap overwrites pending (last wins).
- Simultaneous load and wrap: the wrap copies the old pending buffer to active. The new load data goes to pending and busy_pending stays 1.
- Slot display, using active buffer entries for idx:
  - prescaler < BLANK_CYCLES: all digits inactive, segments off.
  - Otherwise: digit bit idx is active and all other bits inactive; ssegt shows the hex decode of nibble idx; dp follows dp_in[idx].
- Hex decode (active-low form): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. When SEG_ACTIVE_LOW=0 the pattern is inverted, and likewise for dp.
- A digit is dark (segments off, dp off, digit enable still asserted) when either:
  - blank_in[idx]=1, or
  - lz_en=1 and that digit and every higher digit hold nibble 0.
  - Digit 0 is never suppressed by lz_en.
- Output timing: digit, ssegt and dp are registered. They reflect the prescaler/idx state of the previous cycle, giving a fixed 1-cycle latency. frame_done is registered with the idx update.
- Blank window with BLANK_CYCLES=0: no blank window; the digit switches directly.

Test Plan:
- Reset: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1; hold rst_n=0 for 3 cycles -> digit=4'b1111, ssegt=7'b1111111, dp=1, frame_done=0, busy_pending=0.
- Scan and load: load value=16'h12AF, wait for frame_done, then observe -> digit0 slot ssegt=0001110, digit1 0001000, digit2 0100100, digit3 1111001. The slot order is digit=1110,1101,1011,0111, with one blank cycle (1111) per slot and 4 cycles per slot.
- Tear-free update: load 16'h0000 mid-frame -> display keeps the old value until the cycle frame_done=1, then the new value shows; busy_pending falls on that same edge.
- Leading-zero suppression: lz_en=1, value=16'h0050 -> digits 3 and 2 dark, digit1 shows 0010010, digit0 shows 1000000. With value=16'h0000, only digit0 lit (1000000).
- Decimal point and blanking: dp_in=4'b0100, blank_in=4'b0001 -> dp=0 only in the digit2 slot; digit0 slot ssegt=1111111.
- Simultaneous events: assert load on the wrap cycle, and reset mid-slot -> old pending displayed and busy_pending stays 1; after reset, outputs return to reset values on the next edge and the scan restarts at idx 0.
